// File: rtl/gps_feed_rx_pkg.sv
// gps_feed_rx_pkg
//   Shared definitions for the host sample-feed receiver: bit positions inside
//   the 8-bit PIO word, the sample width and the feed FSM state encoding.
package gps_feed_rx_pkg;

  // Field positions inside the PIO word written by the host.
  localparam int FEED_DATA_MSB  = 2;
  localparam int FEED_DATA_LSB  = 0;
  localparam int FEED_CLK_BIT   = 3;
  localparam int FEED_DONE_BIT  = 6;
  localparam int FEED_RESET_BIT = 7;

  // One sample is {sign, mag[1:0]}.
  localparam int SAMPLE_W = FEED_DATA_MSB - FEED_DATA_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feed_state_t;

endpackage

// File: rtl/gps_feed_rx_if.sv
// gps_feed_rx_if
//   Sample stream from the feed receiver to the subchannel.
//   out_valid : head sample valid (master -> slave)
//   out_data  : head sample {sign, mag[1:0]} (master -> slave)
//   out_ready : slave accepts out_data this cycle (slave -> master)
interface gps_feed_rx_if;
  import gps_feed_rx_pkg::*;

  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/gps_feed_fifo.sv
// gps_feed_fifo
//   Small sample FIFO with a registered head word.
//   clk, reset   : clock, synchronous active-high reset
//   i_push/i_din : write request and data
//   i_pop        : read request (ignored while empty)
//   i_flush      : synchronous clear of all entries
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
//   o_head_valid : registered "not empty", drives the stream valid
//   o_head       : registered oldest entry, stable until popped
module gps_feed_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_head_valid,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             r_head_valid;
  logic [WIDTH-1:0] r_head;

  logic             w_pop;
  logic             w_push;
  logic [AW:0]      w_wr_next;
  logic [AW:0]      w_rd_next;
  logic [WIDTH-1:0] w_head_next;

  // Extra pointer MSB is the wrap bit: equal pointers mean empty,
  // differing wrap bits with equal indices mean full.
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

  // A push into a full FIFO only lands when a pop frees a slot in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  assign w_wr_next = r_wr + {{AW{1'b0}}, w_push};
  assign w_rd_next = r_rd + {{AW{1'b0}}, w_pop};

  // When the new read pointer lands on the slot being written, the FIFO is
  // (or becomes) empty apart from this push, so the head comes straight from i_din.
  assign w_head_next = (w_push && (r_wr == w_rd_next)) ? i_din : r_mem[w_rd_next[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_head_valid <= 1'b0;
      r_head       <= '0;
    end else begin
      r_wr         <= w_wr_next;
      r_rd         <= w_rd_next;
      r_head_valid <= (w_wr_next != w_rd_next);
      r_head       <= w_head_next;
    end
  end

  assign o_head_valid = r_head_valid;
  assign o_head       = r_head;

endmodule

// File: rtl/gps_feed_rx.sv
// gps_feed_rx
//   Receive side of the host sample-feed PIO. Synchronises the asynchronous
//   PIO word, glitch-filters the sample-clock bit, captures one sample per
//   accepted rising edge into a FIFO and streams it out with valid/ready.
//   clk            : correlator clock
//   reset          : synchronous active-high reset
//   gps_data_in    : raw PIO word, asynchronous to clk
//   out_if         : sample stream (master side)
//   sample_count   : accepted edges since reset / feed reset, saturating
//   feed_active    : feed FSM in RUN
//   feed_done      : feed FSM in DONE
//   overflow       : sticky, a sample was dropped on a full FIFO
//   feed_reset_out : synchronised feed-reset bit for the subchannel
module gps_feed_rx
  import gps_feed_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LEVEL   = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           gps_data_in,
  gps_feed_rx_if.master        out_if,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic                 feed_active,
  output logic                 feed_done,
  output logic                 overflow,
  output logic                 feed_reset_out
);

  localparam int RW = $clog2(MIN_LEVEL + 1);

  logic [SYNC_STAGES-1:0][7:0] r_sync;
  logic [RW-1:0]               r_run;
  logic                        r_lvl;
  logic                        r_armed;
  logic                        r_accept;
  logic [SAMPLE_W-1:0]         r_sample;
  feed_state_t                 r_state;
  logic [CNT_WIDTH-1:0]        r_count;
  logic                        r_overflow;

  logic [7:0]    w_sync;
  logic          w_clk_lvl;
  logic          w_done_lvl;
  logic          w_feed_rst;
  logic [RW-1:0] w_run_next;
  logic          w_level_met;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_unused_bits;
  feed_state_t   w_state_next;

  // Synchroniser: every bit of the word shifts through SYNC_STAGES flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gps_data_in};
    end
  end

  assign w_sync        = r_sync[SYNC_STAGES-1];
  assign w_clk_lvl     = w_sync[FEED_CLK_BIT];
  assign w_done_lvl    = w_sync[FEED_DONE_BIT];
  assign w_feed_rst    = w_sync[FEED_RESET_BIT];
  assign w_unused_bits = ^w_sync[5:4];

  // Run length of the current sample-clock level, saturating at MIN_LEVEL.
  always_comb begin
    w_run_next = RW'(1);
    if (w_clk_lvl == r_lvl) begin
      w_run_next = (r_run == RW'(MIN_LEVEL)) ? r_run : r_run + RW'(1);
    end
  end

  assign w_level_met = (w_run_next == RW'(MIN_LEVEL));
  // Only the cycle that first reaches MIN_LEVEL high can accept; armed
  // dropping in the same cycle limits each edge to one accept.
  assign w_accept    = r_armed && w_clk_lvl && w_level_met && !w_feed_rst;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lvl    <= 1'b0;
      r_run    <= '0;
      r_armed  <= 1'b0;
      r_accept <= 1'b0;
      r_sample <= '0;
    end else begin
      r_lvl    <= w_clk_lvl;
      r_run    <= w_run_next;
      r_accept <= w_accept;
      if (w_accept) begin
        r_sample <= w_sync[FEED_DATA_MSB:FEED_DATA_LSB];
      end
      if (w_feed_rst || w_accept) begin
        r_armed <= 1'b0;
      end else if (!w_clk_lvl && w_level_met) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Feed FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Feed FSM: next state. Feed reset wins over every transition.
  always_comb begin
    w_state_next = r_state;
    if (w_feed_rst) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (r_accept)   w_state_next = ST_RUN;
        ST_RUN:  if (w_done_lvl) w_state_next = ST_DONE;
        ST_DONE: w_state_next = ST_DONE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Feed FSM: outputs decoded from the state register.
  always_comb begin
    feed_active = 1'b0;
    feed_done   = 1'b0;
    case (r_state)
      ST_RUN:  feed_active = 1'b1;
      ST_DONE: feed_done   = 1'b1;
      default: ;
    endcase
  end

  assign w_push = r_accept && (r_state != ST_DONE) && !w_feed_rst;
  assign w_pop  = out_if.out_valid && out_if.out_ready && !w_fifo_empty;

  // Counter includes samples that the FIFO drops.
  always_ff @(posedge clk) begin
    if (reset || w_feed_rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && (r_count != {CNT_WIDTH{1'b1}})) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
      if (w_push && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  gps_feed_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_din        (r_sample),
    .i_pop        (w_pop),
    .i_flush      (w_feed_rst),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_head_valid (out_if.out_valid),
    .o_head       (out_if.out_data)
  );

  assign sample_count   = r_count;
  assign overflow       = r_overflow;
  assign feed_reset_out = w_feed_rst;

endmodule

// File: tb/tb_gps_feed_rx.sv
// tb_gps_feed_rx
//   Directed bench for gps_feed_rx. Stimulus pushes expected samples into a
//   queue; an independent monitor pops and compares on every handshake.
module tb_gps_feed_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  gps;
  logic [15:0] cnt;
  logic        act;
  logic        done;
  logic        ovf;
  logic        frst;

  gps_feed_rx_if bus ();

  gps_feed_rx #(
    .SYNC_STAGES (2),
    .MIN_LEVEL   (2),
    .FIFO_DEPTH  (4),
    .CNT_WIDTH   (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .gps_data_in    (gps),
    .out_if         (bus),
    .sample_count   (cnt),
    .feed_active    (act),
    .feed_done      (done),
    .overflow       (ovf),
    .feed_reset_out (frst)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         pops     = 0;
  logic [2:0] exp_q[$];
  bit         lat_arm  = 1'b0;
  int         first_valid_cyc = -1;

  always @(posedge clk) cyc++;

  // Monitor: compares every accepted output sample with the queue head.
  always @(negedge clk) begin
    logic [2:0] ex;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      pops++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got=%0d required=no_sample", bus.out_data);
      end else begin
        ex = exp_q.pop_front();
        if (bus.out_data !== ex) begin
          failures++;
          $display("FAIL pop_data got=%0d required=%0d", bus.out_data, ex);
        end else begin
          $display("pop data=%0d", bus.out_data);
        end
      end
    end
    if (lat_arm && bus.out_valid === 1'b1) begin
      first_valid_cyc = cyc;
      lat_arm = 1'b0;
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end else begin
      $display("ok %s = %0d", name, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gps = 8'h00;
    bus.out_ready = 1'b0;
    tick(4);
    reset = 1'b0;
    exp_q.delete();
    tick(4);
  endtask

  // One sample-clock period: 20 cycles high, 20 low. Optionally raises
  // out_ready for exactly the cycle in which the sample is pushed.
  task automatic send(input logic [2:0] d, input bit expect_push, input bit ready_pulse);
    gps[2:0] = d;
    gps[3] = 1'b1;
    if (expect_push) exp_q.push_back(d);
    $display("edge data=%0d expect_push=%0d", d, expect_push);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ready_pulse && i == 3) bus.out_ready = 1'b1;
      if (ready_pulse && i == 4) bus.out_ready = 1'b0;
    end
    gps[3] = 1'b0;
    tick(20);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    tick(3);
    check("drain_remaining", exp_q.size(), 0);
  endtask

  initial begin
    int rise_cyc;
    int pops0;

    // Reset state
    do_reset();
    check("rst_valid", bus.out_valid, 0);
    check("rst_count", cnt, 0);
    check("rst_active", act, 0);
    check("rst_done", done, 0);
    check("rst_overflow", ovf, 0);
    check("rst_feed_reset", frst, 0);

    // Test 1: ten clean edges, latency of the first
    bus.out_ready = 1'b1;
    rise_cyc = cyc;
    lat_arm = 1'b1;
    send(3'd0, 1'b1, 1'b0);
    check("t1_latency", first_valid_cyc - rise_cyc, 5);
    for (int k = 1; k < 10; k++) send(3'(k % 8), 1'b1, 1'b0);
    wait_drain();
    check("t1_count", cnt, 10);
    check("t1_active", act, 1);

    // Test 2: one-cycle glitch between two clean edges
    do_reset();
    bus.out_ready = 1'b1;
    send(3'd3, 1'b1, 1'b0);
    gps[2:0] = 3'd5;
    gps[3] = 1'b1;
    tick(1);
    gps[3] = 1'b0;
    tick(20);
    send(3'd6, 1'b1, 1'b0);
    wait_drain();
    check("t2_count", cnt, 2);

    // Test 3: overflow with out_ready low, then drain
    do_reset();
    for (int k = 1; k <= 6; k++) send(3'(k), (k <= 4), 1'b0);
    check("t3_overflow", ovf, 1);
    check("t3_count", cnt, 6);
    check("t3_valid", bus.out_valid, 1);
    check("t3_head_held", bus.out_data, 1);
    pops0 = pops;
    bus.out_ready = 1'b1;
    wait_drain();
    check("t3_pops", pops - pops0, 4);
    check("t3_overflow_sticky", ovf, 1);
    // Feed reset clears the sticky overflow
    bus.out_ready = 1'b0;
    gps[7] = 1'b1;
    tick(4);
    check("t3_overflow_cleared", ovf, 0);
    gps[7] = 1'b0;

    // Test 4: push into full FIFO with a simultaneous pop
    do_reset();
    send(3'd7, 1'b1, 1'b0);
    send(3'd6, 1'b1, 1'b0);
    send(3'd5, 1'b1, 1'b0);
    send(3'd4, 1'b1, 1'b0);
    check("t4_full_no_overflow", ovf, 0);
    send(3'd3, 1'b1, 1'b1);
    check("t4_overflow", ovf, 0);
    check("t4_count", cnt, 5);
    check("t4_valid", bus.out_valid, 1);
    pops0 = pops;
    bus.out_ready = 1'b1;
    wait_drain();
    check("t4_remaining_pops", pops - pops0, 4);

    // Test 5: feed complete after three edges
    do_reset();
    bus.out_ready = 1'b1;
    send(3'd2, 1'b1, 1'b0);
    send(3'd4, 1'b1, 1'b0);
    send(3'd6, 1'b1, 1'b0);
    check("t5_active_run", act, 1);
    gps[6] = 1'b1;
    tick(5);
    check("t5_done", done, 1);
    check("t5_active", act, 0);
    send(3'd1, 1'b0, 1'b0);
    send(3'd3, 1'b0, 1'b0);
    wait_drain();
    check("t5_count", cnt, 3);
    check("t5_done_hold", done, 1);

    // Test 6: feed reset mid-stream, then restart
    do_reset();
    send(3'd5, 1'b1, 1'b0);
    send(3'd2, 1'b1, 1'b0);
    check("t6_valid_before", bus.out_valid, 1);
    check("t6_count_before", cnt, 2);
    gps[7] = 1'b1;
    tick(4);
    check("t6_valid", bus.out_valid, 0);
    check("t6_count", cnt, 0);
    check("t6_overflow", ovf, 0);
    check("t6_active", act, 0);
    check("t6_done", done, 0);
    check("t6_feed_reset_out", frst, 1);
    exp_q.delete();
    gps[7] = 1'b0;
    tick(6);
    check("t6_feed_reset_release", frst, 0);
    bus.out_ready = 1'b1;
    send(3'd7, 1'b1, 1'b0);
    wait_drain();
    check("t6_restart_count", cnt, 1);
    check("t6_restart_active", act, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
